cell_draw_datapath: RTL and testbench
=====================================

// Module: cell_draw_datapath
// PURPOSE
//  Downstream pixel generator for the Connect Four VGA draw path. The draw-control FSM
//  hands it one request: a disc at (col,row), or the column pointer above the board.
//  It walks the cell's CELL_SIZE x CELL_SIZE square and emits one x/y/colour/plot per
//  cycle for the VGA adapter. In pointer mode it first erases the old pointer cell.
// PARAMETERS
//  CELL_SIZE  4   square edge in pixels (4..15)
//  COLS       7   board columns
//  ROWS       6   board rows; row 0 is the bottom row
//  X_ORIGIN   0   x of column 0's left edge
//  Y_ORIGIN   8   y of the top board row's top edge; must be >= CELL_SIZE
//  X_W        8   x output width
//  Y_W        7   y output width
// PORTS
//  clk      in   1    system clock
//  resetn   in   1    reset; one clock; reset is synchronous and active-high
//  start    in   1    request strobe; sampled only in IDLE
//  mode     in   1    0 = disc, 1 = pointer
//  col      in   3    target column
//  row      in   3    target row (ignored in pointer mode)
//  player   in   1    0 = red (3'b100), 1 = yellow (3'b110)
//  busy     out  1    high from the cycle after accept until DONE exits
//  done     out  1    single-cycle completion pulse
//  err      out  1    high with done when the request was out of range
//  x        out  X_W  pixel x
//  y        out  Y_W  pixel y
//  colour   out  3    pixel colour; background is 3'b000
//  plot     out  1    pixel write enable to the VGA adapter
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, err, plot, x, y, colour = 0; last_col = 0;
//    dx, dy = 0. Reset mid-operation aborts the request and emits no further pixels.
//  - Accept (IDLE & start): latch mode, col, row, player. start is ignored in other states.
//  - Range check at accept: col>=COLS, or mode=0 & row>=ROWS -> ERRDONE. No plot.
//  - States: IDLE, ERASE, DRAW, DONE, ERRDONE.
//  - Transitions:
//    IDLE->DRAW if mode=0.
//    IDLE->ERASE if mode=1 and col!=last_col.
//    IDLE->DRAW if mode=1 and col==last_col (erase skipped).
//    ERASE->DRAW after the last pixel. DRAW->DONE after the last pixel.
//    DONE->IDLE and ERRDONE->IDLE unconditionally.
//  - Scan: dx is the fast counter and dy the slow one, each 0..CELL_SIZE-1. One pixel
//    per cycle with plot=1 for every ERASE and DRAW cycle. The counters clear on entry
//    to each scanning state.
//  - Addressing, computed at full width then truncated to X_W/Y_W:
//    x = X_ORIGIN + c*CELL_SIZE + dx.
//    Disc y = Y_ORIGIN + (ROWS-1-row)*CELL_SIZE + dy.
//    Pointer y = Y_ORIGIN - CELL_SIZE + dy.
//    ERASE uses c = last_col; DRAW uses c = latched col.
//  - Colour: ERASE -> 3'b000; DRAW -> player colour.
//  - Outputs are registered. With accept on edge T:
//    first plot at T+1;
//    disc: N = CELL_SIZE^2 plot cycles, then done at T+N+1;
//    pointer with erase: 2N plot cycles, then done at T+2N+1;
//    error: done=err=1 at T+1.
//  - last_col updates to the latched col in the DONE cycle of a pointer request. Disc
//    and error requests leave it unchanged.
//  - Outside ERASE/DRAW: plot=0. x, y, colour hold their last value.
//  - start held high through DONE is accepted again on the IDLE cycle that follows.
// TESTING
//  - Reset, then disc col=0,row=0,player=0 -> 16 plots: x 0..3, y 28..31, colour 3'b100,
//    raster order; done at T+17.
//  - Pointer col=3,player=1 after reset -> erase col 0 at y 4..7 in 3'b000, then draw at
//    x 12..15 in 3'b110; done at T+33; last_col=3.
//  - Pointer col=3 again -> no erase, 16 plots, done at T+17.
//  - Disc col=7 or row=6 -> done=err=1 at T+1, plot never asserted, last_col unchanged.
//  - start pulsed while busy -> ignored; exactly one done per accepted request.
//  - resetn asserted at the 5th pixel of a pointer draw -> next cycle plot=0, IDLE,
//    last_col=0.

Source files
------------

// File: rtl/cell_draw_datapath.sv
// Pixel generator for the Connect Four board draw path.
// Accepts one request (disc at col/row, or column pointer above the board),
// raster-scans the CELL_SIZE x CELL_SIZE cell and emits one registered
// x/y/colour/plot per cycle. Pointer requests first erase the previous
// pointer cell unless the pointer has not moved.
// Note: resetn is active-high despite its name.
module cell_draw_datapath #(
    parameter int CELL_SIZE = 4,
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 8,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           mode,
    input  logic [2:0]     col,
    input  logic [2:0]     row,
    input  logic           player,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE,
        S_ERRDONE
    } state_t;

    localparam logic [3:0] LAST      = 4'(CELL_SIZE - 1);
    localparam logic [2:0] C_BLACK   = 3'b000;
    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_YELLOW  = 3'b110;

    state_t         state_q;
    logic           busy_q, done_q, err_q, plot_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [2:0]     colour_q;
    logic [3:0]     dx_q, dy_q;
    logic [2:0]     last_col_q;

    // Latched request; never observed before being written on accept.
    logic           mode_q, player_q;
    logic [2:0]     col_q, row_q;

    logic [2:0]     c_sel;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic [2:0]     colour_d;
    logic [3:0]     dx_d, dy_d;
    logic           last_pix;
    logic           req_bad;

    // Pixel address, colour and next scan position for the current cell.
    always_comb begin
        c_sel    = (state_q == S_ERASE) ? last_col_q : col_q;
        x_d      = X_W'(X_ORIGIN + 32'(c_sel) * CELL_SIZE + 32'(dx_q));
        if (state_q == S_DRAW && !mode_q)
            y_d = Y_W'(Y_ORIGIN + (ROWS - 1 - 32'(row_q)) * CELL_SIZE + 32'(dy_q));
        else
            y_d = Y_W'(Y_ORIGIN - CELL_SIZE + 32'(dy_q));
        colour_d = (state_q == S_ERASE) ? C_BLACK : (player_q ? C_YELLOW : C_RED);
        last_pix = (dx_q == LAST) && (dy_q == LAST);
        dx_d     = dx_q + 4'd1;
        dy_d     = dy_q;
        if (dx_q == LAST) begin
            dx_d = 4'd0;
            dy_d = (dy_q == LAST) ? 4'd0 : dy_q + 4'd1;
        end
        req_bad  = (32'(col) >= COLS) || (!mode && (32'(row) >= ROWS));
    end

    // Request FSM with registered pixel and handshake outputs.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            plot_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            last_col_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            plot_q <= 1'b0;
            busy_q <= (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    dx_q <= '0;
                    dy_q <= '0;
                    if (start) begin
                        mode_q   <= mode;
                        col_q    <= col;
                        row_q    <= row;
                        player_q <= player;
                        if (req_bad)
                            state_q <= S_ERRDONE;
                        else if (mode && (col != last_col_q))
                            state_q <= S_ERASE;
                        else
                            state_q <= S_DRAW;
                    end
                end
                S_ERASE, S_DRAW: begin
                    plot_q   <= 1'b1;
                    x_q      <= x_d;
                    y_q      <= y_d;
                    colour_q <= colour_d;
                    dx_q     <= dx_d;
                    dy_q     <= dy_d;
                    if (last_pix)
                        state_q <= (state_q == S_ERASE) ? S_DRAW : S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (mode_q)
                        last_col_q <= col_q;
                    state_q <= S_IDLE;
                end
                S_ERRDONE: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_cell_draw_datapath.sv
// Directed bench for cell_draw_datapath with the default parameters
// (4x4 cells, 7x6 board, X_ORIGIN=0, Y_ORIGIN=8).
module tb_cell_draw_datapath;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       mode;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
    logic       busy, done, err, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_checks = 0;
    int n_errors = 0;

    cell_draw_datapath dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .mode   (mode),
        .col    (col),
        .row    (row),
        .player (player),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to done. Cycle k is sampled at the
    // falling edge after rising edge T+k, where T is the accept edge.
    // Expected pixel i of each phase is (xbase + i%4, ybase + i/4).
    task automatic run_req(input string tag, input logic m, input logic [2:0] c,
                           input logic [2:0] r, input logic p,
                           input int xe, input int ye, input int n_erase,
                           input int xd, input int yd, input int cold, input int n_draw,
                           input int exp_err, input int pulse_k);
        int k, np, j;
        bit fin;
        @(negedge clk);
        start = 1'b1; mode = m; col = c; row = r; player = p;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":plot_at_accept"}, int'(plot), 0);
        k = 0; np = 0; fin = 0;
        while (!fin && k < 80) begin
            @(negedge clk);
            k++;
            if (k == pulse_k) begin
                start = 1'b1; col = 3'd1; mode = 1'b1;
            end else if (k == pulse_k + 1) begin
                start = 1'b0;
            end
            if (k == 1) check({tag, ":busy_k1"}, int'(busy), 1);
            if (plot) begin
                check({tag, ":plot_cycle"}, k, np + 1);
                if (np < n_erase) begin
                    check({tag, ":ex"}, int'(x), xe + np % 4);
                    check({tag, ":ey"}, int'(y), ye + np / 4);
                    check({tag, ":ecol"}, int'(colour), 0);
                end else begin
                    j = np - n_erase;
                    check({tag, ":dx"}, int'(x), xd + j % 4);
                    check({tag, ":dy"}, int'(y), yd + j / 4);
                    check({tag, ":dcol"}, int'(colour), cold);
                end
                np++;
            end
            if (done) begin
                fin = 1;
                check({tag, ":done_cycle"}, k, n_erase + n_draw + 1);
                check({tag, ":err"}, int'(err), exp_err);
                check({tag, ":plots"}, np, n_erase + n_draw);
                check({tag, ":plot_with_done"}, int'(plot), 0);
            end
        end
        if (!fin) check({tag, ":timeout"}, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, ":extra_done"}, int'(done), 0);
            check({tag, ":idle_busy"}, int'(busy), 0);
            check({tag, ":idle_plot"}, int'(plot), 0);
        end
    endtask

    initial begin
        int np;
        resetn = 1'b1; start = 1'b0; mode = 1'b0; col = 3'd0; row = 3'd0; player = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);

        // Disc bottom-left, red.
        run_req("disc00", 1'b0, 3'd0, 3'd0, 1'b0, 0, 0, 0, 0, 28, 4, 16, 0, 0);
        // Pointer moves 0 -> 3: erase col 0, draw col 3 yellow.
        run_req("ptr3", 1'b1, 3'd3, 3'd0, 1'b1, 0, 4, 16, 12, 4, 6, 16, 0, 0);
        // Pointer unchanged: no erase.
        run_req("ptr3b", 1'b1, 3'd3, 3'd0, 1'b1, 0, 0, 0, 12, 4, 6, 16, 0, 0);
        // Out of range requests.
        run_req("badcol", 1'b0, 3'd7, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_req("badrow", 1'b0, 3'd2, 3'd6, 1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Pointer still at 3 after errors.
        run_req("ptr3c", 1'b1, 3'd3, 3'd0, 1'b0, 0, 0, 0, 12, 4, 4, 16, 0, 0);
        // Top-right disc, with a start pulse while busy.
        run_req("disc65", 1'b0, 3'd6, 3'd5, 1'b1, 0, 0, 0, 24, 8, 6, 16, 0, 5);
        // Mid-board disc.
        run_req("disc23", 1'b0, 3'd2, 3'd3, 1'b0, 0, 0, 0, 8, 16, 4, 16, 0, 0);

        // Reset on the 5th pixel of a pointer request.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; col = 3'd5; player = 1'b0;
        @(negedge clk);
        start = 1'b0;
        np = 0;
        for (int k = 0; k < 40 && np < 5; k++) begin
            @(negedge clk);
            if (plot) np++;
        end
        check("rst_mid_reached", np, 5);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check("rst_mid_plot", int'(plot), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_x", int'(x), 0);
        check("rst_mid_y", int'(y), 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_quiet", int'(plot), 0);
        end
        // last_col back to 0: pointer at col 0 needs no erase.
        run_req("ptr0", 1'b1, 3'd0, 3'd0, 1'b0, 0, 0, 0, 0, 4, 4, 16, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
